dmem_port_arbiter: RTL

//  Shares the single data port of unified_memory between two requesters: M0 = riscv_cpu data path, M1 = DMA/loader.

---
 rtl/dmem_port_arbiter.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/dmem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_port_arbiter
//  Description : Two-master arbiter for the unified_memory data port, using
//                round-robin with a capped M1 burst lock and an address range
//                check on every access.
//  Revision    : 1.0
// ============================================================================
module dmem_port_arbiter #(
    parameter logic [31:0] MEM_SIZE  = 32'h0001_0000,
    parameter int          MAX_BURST = 8,
    parameter int          CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,

    input  logic             m0_req,
    input  logic             m0_we,
    input  logic [31:0]      m0_addr,
    input  logic [31:0]      m0_wdata,
    input  logic [3:0]       m0_be,
    input  logic [2:0]       m0_load_type,
    output logic             m0_gnt,
    output logic             m0_rvalid,
    output logic [31:0]      m0_rdata,
    output logic             m0_err,

    input  logic             m1_req,
    input  logic             m1_we,
    input  logic [31:0]      m1_addr,
    input  logic [31:0]      m1_wdata,
    input  logic [3:0]       m1_be,
    input  logic [2:0]       m1_load_type,
    output logic             m1_gnt,
    output logic             m1_rvalid,
    output logic [31:0]      m1_rdata,
    output logic             m1_err,
    input  logic             m1_lock,

    output logic [31:0]      mem_addr,
    output logic [31:0]      mem_write_data,
    output logic             mem_write_enable,
    output logic             mem_read_enable,
    output logic [3:0]       mem_byte_enable,
    output logic [2:0]       mem_load_type,
    input  logic [31:0]      mem_read_data,

    output logic [CNT_W-1:0] contention_cnt
);

    localparam logic [7:0] c_max_burst = 8'(MAX_BURST);

    logic             r_last_winner;   // 1 = M1 won the most recent grant
    logic             r_lock_owner;
    logic [7:0]       r_burst_cnt;
    logic [1:0]       r_rd_pend;       // in-range read issued last cycle, per master
    logic [1:0]       r_err_pend;      // out-of-range access issued last cycle, per master
    logic [CNT_W-1:0] r_contention;

    logic w_both;
    logic w_gnt0;
    logic w_gnt1;
    logic w_oor0;
    logic w_oor1;
    logic w_sel_oor;

    assign w_both = m0_req & m1_req;
    assign w_oor0 = (m0_addr >= MEM_SIZE);
    assign w_oor1 = (m1_addr >= MEM_SIZE);

    always_comb begin
        w_gnt0 = 1'b0;
        w_gnt1 = 1'b0;
        if (w_both) begin
            if (r_lock_owner && (r_burst_cnt < c_max_burst)) begin
                w_gnt1 = 1'b1;
            end else if (r_last_winner) begin
                w_gnt0 = 1'b1;
            end else begin
                w_gnt1 = 1'b1;
            end
        end else begin
            w_gnt0 = m0_req;
            w_gnt1 = m1_req;
        end
    end

    assign m0_gnt = w_gnt0;
    assign m1_gnt = w_gnt1;

    // Granted master's fields reach memory; enables are suppressed when out of range.
    always_comb begin
        mem_addr         = '0;
        mem_write_data   = '0;
        mem_write_enable = 1'b0;
        mem_read_enable  = 1'b0;
        mem_byte_enable  = '0;
        mem_load_type    = '0;
        w_sel_oor        = 1'b0;
        if (w_gnt1) begin
            w_sel_oor        = w_oor1;
            mem_addr         = m1_addr;
            mem_write_data   = m1_wdata;
            mem_byte_enable  = m1_be;
            mem_load_type    = m1_load_type;
            mem_write_enable = m1_we & ~w_sel_oor;
            mem_read_enable  = ~m1_we & ~w_sel_oor;
        end else if (w_gnt0) begin
            w_sel_oor        = w_oor0;
            mem_addr         = m0_addr;
            mem_write_data   = m0_wdata;
            mem_byte_enable  = m0_be;
            mem_load_type    = m0_load_type;
            mem_write_enable = m0_we & ~w_sel_oor;
            mem_read_enable  = ~m0_we & ~w_sel_oor;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_last_winner <= 1'b1;
            r_lock_owner  <= 1'b0;
            r_burst_cnt   <= '0;
            r_rd_pend     <= '0;
            r_err_pend    <= '0;
            r_contention  <= '0;
        end else begin
            r_rd_pend  <= {w_gnt1 & ~m1_we & ~w_oor1, w_gnt0 & ~m0_we & ~w_oor0};
            r_err_pend <= {w_gnt1 & w_oor1, w_gnt0 & w_oor0};

            if (w_gnt0 || w_gnt1) begin
                r_last_winner <= w_gnt1;
                r_lock_owner  <= w_gnt1 & m1_lock;
            end

            // Burst length only counts M1 beats that actually kept M0 waiting.
            if (w_gnt0) begin
                r_burst_cnt <= '0;
            end else if (w_gnt1) begin
                if (!m1_lock) begin
                    r_burst_cnt <= '0;
                end else if (m0_req && (r_burst_cnt != 8'hFF)) begin
                    r_burst_cnt <= r_burst_cnt + 8'd1;
                end
            end

            if (w_both && (r_contention != {CNT_W{1'b1}})) begin
                r_contention <= r_contention + CNT_W'(1);
            end
        end
    end

    assign m0_rvalid = r_rd_pend[0] | r_err_pend[0];
    assign m0_err    = r_err_pend[0];
    assign m0_rdata  = r_rd_pend[0] ? mem_read_data : 32'h0;

    assign m1_rvalid = r_rd_pend[1] | r_err_pend[1];
    assign m1_err    = r_err_pend[1];
    assign m1_rdata  = r_rd_pend[1] ? mem_read_data : 32'h0;

    assign contention_cnt = r_contention;

endmodule
`default_nettype wire
